// File: rtl/sw_target_feeder_if.sv
// Upstream target-base stream: valid/ready handshake carrying a 2-bit base and
// an end-of-sequence marker.
interface sw_target_feeder_if;
    logic       s_valid;
    logic       s_ready;
    logic [1:0] s_base;
    logic       s_last;

    modport master (output s_valid, output s_base, output s_last, input s_ready);
    modport slave  (input s_valid, input s_base, input s_last, output s_ready);
endinterface

// File: rtl/sw_target_feeder.sv
// Buffers target bases and feeds PE0 of the Smith-Waterman array with
// gap-free per-sequence bursts separated by a minimum idle gap.
module sw_target_feeder #(
    parameter int                     SCORE_WIDTH = 12,
    parameter logic [SCORE_WIDTH-1:0] ZERO        = {1'b1, {(SCORE_WIDTH-1){1'b0}}},
    parameter int                     FIFO_DEPTH  = 8,
    parameter int                     LEN_WIDTH   = 16,
    parameter int                     MIN_GAP     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    sw_target_feeder_if.slave      s,
    output logic                   en_out,
    output logic [1:0]             data_out,
    output logic [SCORE_WIDTH-1:0] M_out,
    output logic [SCORE_WIDTH-1:0] I_out,
    output logic [SCORE_WIDTH-1:0] High_out,
    output logic                   seq_done,
    output logic [LEN_WIDTH-1:0]   seq_len,
    output logic                   err_underrun
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(MIN_GAP + 1);

    typedef enum logic [1:0] {IDLE, STREAM, GAP, DROP} state_t;

    state_t               state, state_n;
    logic [2:0]           mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count, last_cnt;
    logic [LEN_WIDTH-1:0] len, len_n, seq_len_n;
    logic [GW-1:0]        gap_cnt, gap_n;
    logic                 push, pop, empty, start;
    logic                 en_n, done_n, err_n;
    logic [1:0]           data_n;
    logic [2:0]           head;

    assign s.s_ready = (count != CW'(FIFO_DEPTH));
    assign push      = s.s_valid && s.s_ready;
    assign empty     = (count == '0);
    assign head      = mem[rd_ptr];
    // Only start when the whole sequence is buffered, or when the FIFO is full
    // and the remainder is expected to keep pace.
    assign start     = (last_cnt != '0) || (count == CW'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {s.s_last, s.s_base};
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        en_n      = 1'b0;
        data_n    = 2'b00;
        len_n     = len;
        done_n    = 1'b0;
        seq_len_n = seq_len;
        gap_n     = gap_cnt;
        err_n     = err_underrun;
        unique case (state)
            IDLE: if (start) begin
                pop     = 1'b1;
                en_n    = 1'b1;
                data_n  = head[1:0];
                len_n   = LEN_WIDTH'(1);
                state_n = head[2] ? GAP : STREAM;
            end
            STREAM: if (!empty) begin
                pop    = 1'b1;
                en_n   = 1'b1;
                data_n = head[1:0];
                len_n  = (&len) ? len : len + 1'b1;
                if (head[2]) state_n = GAP;
            end else begin
                err_n   = 1'b1;
                state_n = DROP;
            end
            GAP: begin
                gap_n = gap_cnt - 1'b1;
                if (gap_cnt == GW'(1)) state_n = IDLE;
            end
            DROP: if (!empty) begin
                pop = 1'b1;
                if (head[2]) begin
                    gap_n   = GW'(MIN_GAP);
                    state_n = GAP;
                end
            end
            default: state_n = IDLE;
        endcase
        // A last popped while issuing (not discarding) completes a sequence.
        if (pop && head[2] && state != DROP) begin
            done_n    = 1'b1;
            seq_len_n = len_n;
            gap_n     = GW'(MIN_GAP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            last_cnt     <= '0;
            len          <= '0;
            gap_cnt      <= '0;
            en_out       <= 1'b0;
            data_out     <= 2'b00;
            M_out        <= ZERO;
            I_out        <= ZERO;
            High_out     <= ZERO;
            seq_done     <= 1'b0;
            seq_len      <= '0;
            err_underrun <= 1'b0;
        end else begin
            state        <= state_n;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count        <= count + CW'(push) - CW'(pop);
            last_cnt     <= last_cnt + CW'(push && s.s_last) - CW'(pop && head[2]);
            len          <= len_n;
            gap_cnt      <= gap_n;
            en_out       <= en_n;
            data_out     <= data_n;
            M_out        <= ZERO;
            I_out        <= ZERO;
            High_out     <= ZERO;
            seq_done     <= done_n;
            seq_len      <= seq_len_n;
            err_underrun <= err_n;
        end
    end
endmodule

// File: tb/tb_sw_target_feeder.sv
// Bench for sw_target_feeder: queue-based reference model checked every cycle,
// plus hand-computed expectations for the directed scenarios.
module tb_sw_target_feeder;
    localparam int SW = 12, DEPTH = 8, LW = 16, GAPC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sw_target_feeder_if bus();
    logic          en_out, seq_done, err_underrun;
    logic [1:0]    data_out;
    logic [SW-1:0] M_out, I_out, High_out;
    logic [LW-1:0] seq_len;

    sw_target_feeder #(.SCORE_WIDTH(SW), .FIFO_DEPTH(DEPTH), .LEN_WIDTH(LW), .MIN_GAP(GAPC)) dut (
        .clk(clk), .rst(rst), .s(bus), .en_out(en_out), .data_out(data_out),
        .M_out(M_out), .I_out(I_out), .High_out(High_out), .seq_done(seq_done),
        .seq_len(seq_len), .err_underrun(err_underrun));

    int total = 0, bad = 0;
    bit chk_on = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: buffered entries in a queue; a sequence is either being
    // issued, being thrown away after an underrun, or we are cooling down.
    logic [2:0] mq[$];
    int   mode = 0;     // 0 waiting, 1 issuing, 2 discarding
    int   cool = 0, cur_len = 0, e_len = 0;
    logic e_en = 0, e_done = 0, e_err = 0;
    logic [1:0] e_data = 0;

    task automatic model_step();
        logic [2:0] h;
        bit do_push;
        int nl;
        if (!rst) begin
            mq.delete(); mode = 0; cool = 0; cur_len = 0;
            e_en = 0; e_data = 0; e_done = 0; e_len = 0; e_err = 0;
            return;
        end
        do_push = bus.s_valid && (mq.size() < DEPTH);
        nl = 0;
        foreach (mq[i]) if (mq[i][2]) nl++;
        e_en = 0; e_data = 0; e_done = 0;
        if (cool > 0) cool--;
        else if (mode == 2) begin
            if (mq.size() > 0) begin
                h = mq.pop_front();
                if (h[2]) begin mode = 0; cool = GAPC; end
            end
        end else if (mode == 1 && mq.size() == 0) begin
            e_err = 1; mode = 2;
        end else if (mode == 1 || nl > 0 || mq.size() == DEPTH) begin
            h = mq.pop_front();
            e_en = 1; e_data = h[1:0];
            cur_len = (mode == 0) ? 1 : ((cur_len == 65535) ? cur_len : cur_len + 1);
            mode = 1;
            if (h[2]) begin e_done = 1; e_len = cur_len; mode = 0; cool = GAPC; end
        end
        if (do_push) mq.push_back({bus.s_last, bus.s_base});
    endtask

    always @(posedge clk) model_step();

    // Per-cycle comparison plus activity counters for the directed checks.
    int en_cnt = 0, done_cnt = 0;
    bit rdy_low_seen = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("en_out", en_out, e_en);
            chk("data_out", data_out, e_data);
            chk("seq_done", seq_done, e_done);
            chk("seq_len", seq_len, e_len);
            chk("err_underrun", err_underrun, e_err);
            chk("s_ready", bus.s_ready, mq.size() != DEPTH);
            chk("M_out", M_out, 2048);
            chk("I_out", I_out, 2048);
            chk("High_out", High_out, 2048);
            if (en_out === 1'b1) en_cnt++;
            if (seq_done === 1'b1) done_cnt++;
            if (bus.s_ready === 1'b0) rdy_low_seen = 1;
        end
    end

    task automatic push(input logic [1:0] b, input logic l);
        int w = 0;
        logic ok;
        bus.s_valid = 1; bus.s_base = b; bus.s_last = l;
        do begin
            @(negedge clk); ok = bus.s_ready;
            @(posedge clk); #1; w++;
        end while (!ok && w < 200);
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bus.s_valid = 0; bus.s_last = 0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input string nm);
        int w = 0;
        do begin @(negedge clk); w++; end while (en_out !== 1'b1 && w < 50);
        chk(nm, en_out, 1);
    endtask

    initial begin
        int e0, d0;
        int exp_en[6]   = '{1, 1, 0, 0, 1, 0};
        int exp_dat[6]  = '{1, 2, 0, 0, 3, 0};
        int exp_done[6] = '{0, 1, 0, 0, 1, 0};
        bus.s_valid = 0; bus.s_base = 0; bus.s_last = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1; chk_on = 1;

        // reset state
        @(negedge clk);
        chk("rst_en", en_out, 0);
        chk("rst_data", data_out, 0);
        chk("rst_M", M_out, 2048);
        chk("rst_done", seq_done, 0);
        chk("rst_err", err_underrun, 0);
        chk("rst_ready", bus.s_ready, 1);
        @(posedge clk); #1;

        // A,G,T,C in one sequence
        push(0, 0); push(1, 0); push(2, 0); push(3, 1);
        idle(0);
        wait_en("t2_start");
        for (int i = 0; i < 4; i++) begin
            chk("t2_en", en_out, 1);
            chk("t2_data", data_out, i);
            chk("t2_done", seq_done, i == 3);
            if (i == 3) chk("t2_len", seq_len, 4);
            @(negedge clk);
        end
        chk("t2_en_after", en_out, 0);
        idle(10);

        // two short sequences queued back-to-back: exact gap
        push(1, 0); push(2, 1); push(3, 1);
        idle(0);
        wait_en("t3_start");
        for (int i = 0; i < 6; i++) begin
            chk("t3_en", en_out, exp_en[i]);
            chk("t3_data", data_out, exp_dat[i]);
            chk("t3_done", seq_done, exp_done[i]);
            if (i == 1) chk("t3_len1", seq_len, 2);
            if (i == 4) chk("t3_len2", seq_len, 1);
            @(negedge clk);
        end
        idle(10);

        // start on full, then underrun, discard, recover
        e0 = en_cnt; d0 = done_cnt;
        for (int i = 0; i < 8; i++) push(2'(i), 0);
        idle(20);
        chk("t4_en_cycles", en_cnt - e0, 8);
        chk("t4_err", err_underrun, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        e0 = en_cnt;
        push(1, 0); push(2, 0); push(3, 1);
        idle(10);
        chk("t4_drop_en", en_cnt - e0, 0);
        chk("t4_drop_done", done_cnt - d0, 0);
        push(0, 1);
        idle(10);
        chk("t4_rec_done", done_cnt - d0, 1);
        chk("t4_rec_len", seq_len, 1);
        chk("t4_rec_en", en_cnt - e0, 1);

        // back-pressure: fill faster than single-base sequences drain
        d0 = done_cnt; rdy_low_seen = 0;
        for (int i = 0; i < 30; i++) push(2'($urandom_range(0, 3)), 1);
        idle(150);
        chk("t5_ready_low", rdy_low_seen, 1);
        chk("t5_all_issued", done_cnt - d0, 30);

        // reset in the middle of a sustained burst
        bus.s_valid = 1; bus.s_last = 0;
        for (int i = 0; i < 20; i++) begin
            bus.s_base = 2'($urandom_range(0, 3));
            @(posedge clk); #1;
        end
        rst = 0; bus.s_valid = 0;
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("t6_en", en_out, 0);
        chk("t6_err", err_underrun, 0);
        chk("t6_ready", bus.s_ready, 1);
        @(posedge clk); #1;
        d0 = done_cnt;
        push(1, 0); push(2, 1);
        idle(15);
        chk("t6_done", done_cnt - d0, 1);
        chk("t6_len", seq_len, 2);

        // randomized traffic with varying sequence lengths and rare resets
        for (int c = 0; c < 4000; c++) begin
            int p_last, p_valid;
            p_last  = (c / 500) % 4 == 0 ? 2 : (c / 500) % 4 == 1 ? 5 : (c / 500) % 4 == 2 ? 12 : 40;
            p_valid = ((c / 250) % 2 == 0) ? 8 : 2;
            bus.s_valid = ($urandom_range(0, 9) < p_valid);
            bus.s_base  = 2'($urandom_range(0, 3));
            bus.s_last  = ($urandom_range(0, p_last - 1) == 0);
            rst = ($urandom_range(0, 699) != 0);
            @(posedge clk); #1;
        end
        rst = 1;
        idle(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
